muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one step per cycle, signed handling via magnitude datapath plus final sign fix-up.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcLeft,
  input  logic [WIDTH-1:0] srcRight,
  input  logic             cancel,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divByZero,
  output logic [1:0]       dbgState
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;

  stateT state, nextState;

  logic [CW-1:0]        count;
  logic [WIDTH-1:0]     operand;    // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc;        // {product hi / remainder, multiplier / quotient}
  logic                 negLo, negHi, isDiv, zeroPend;

  logic                 accept, lastStep, signedOp, leftNeg, rightNeg, zeroDiv;
  logic [WIDTH-1:0]     leftMag, rightMag;
  logic [WIDTH:0]       mulSum, divShift, divDiff;
  logic                 divFits;
  logic [2*WIDTH-1:0]   prodFix;
  logic [WIDTH-1:0]     remFix, quotFix;

  // Handshake: start is a request taken only in IDLE without cancel; stall tells the
  // issuing pipeline to hold while a request is being taken or an operation runs.
  assign accept   = (state == IDLE) && start && !cancel;
  assign busy     = (state == MUL) || (state == DIV);
  assign stall    = busy || accept;
  assign dbgState = state;
  assign lastStep = (count == CW'(WIDTH - 1));

  assign signedOp = !op[0];
  assign leftNeg  = signedOp && srcLeft[WIDTH-1];
  assign rightNeg = signedOp && srcRight[WIDTH-1];
  assign leftMag  = leftNeg ? -srcLeft : srcLeft;
  assign rightMag = rightNeg ? -srcRight : srcRight;
  assign zeroDiv  = op[1] && (srcRight == '0);

  assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
  assign divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, operand};
  assign divFits  = !divDiff[WIDTH];

  assign prodFix  = negLo ? -acc : acc;
  assign remFix   = negHi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign quotFix  = negLo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = zeroDiv ? DONE : (op[1] ? DIV : MUL);
      MUL, DIV: begin
        if (cancel)        nextState = IDLE;
        else if (lastStep) nextState = DONE;
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      operand   <= '0;
      acc       <= '0;
      negLo     <= 1'b0;
      negHi     <= 1'b0;
      isDiv     <= 1'b0;
      zeroPend  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          count     <= '0;
          operand   <= rightMag;
          isDiv     <= op[1];
          zeroPend  <= zeroDiv;
          divByZero <= 1'b0;
          if (zeroDiv) begin
            // Raw dividend goes straight to hi; no sign fix-up applies.
            acc   <= {srcLeft, {WIDTH{1'b1}}};
            negLo <= 1'b0;
            negHi <= 1'b0;
          end else begin
            acc   <= {{WIDTH{1'b0}}, leftMag};
            negLo <= leftNeg ^ rightNeg;
            negHi <= op[1] && leftNeg;
          end
        end
        MUL: if (!cancel) begin
          acc   <= {mulSum, acc[WIDTH-1:1]};
          count <= count + CW'(1);
        end
        DIV: if (!cancel) begin
          acc   <= {(divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0]),
                    acc[WIDTH-2:0], divFits};
          count <= count + CW'(1);
        end
        DONE: begin
          hi        <= isDiv ? remFix  : prodFix[2*WIDTH-1:WIDTH];
          lo        <= isDiv ? quotFix : prodFix[WIDTH-1:0];
          done      <= 1'b1;
          divByZero <= zeroPend;
        end
        default: ;
      endcase
    end
  end

endmodule
